// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle EX ALU (Start/ALU_Control/A/B/Shamt in; Result/Zero/Overflow/Illegal/Busy/Done out), bit-serial SLL/SRL
module alu_seq_exec #(
  parameter int WIDTH = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [3:0]         ALU_Control,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic [WIDTH-1:0]   Result,
  output logic               Zero,
  output logic               Overflow,
  output logic               Illegal,
  output logic               Busy,
  output logic               Done
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sreg, sh_next, alu_res, sum, diff;
  logic [SHAMT_W-1:0] cnt;
  logic left, accept, go_shift, last, alu_ovf, bad;
  assign Busy = state == SHIFT;
  always_comb begin
    accept = Start && state == IDLE;
    last = state == SHIFT && cnt == SHAMT_W'(1);
    bad = ALU_Control == 4'd0 || ALU_Control > 4'd9;
    go_shift = (ALU_Control == 4'd3 || ALU_Control == 4'd4) && Shamt != '0;
    sh_next = left ? sreg << 1 : sreg >> 1;
    sum = A + B;
    diff = A - B;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ALU_Control)
      4'd1: begin
        alu_res = sum;
        alu_ovf = A[WIDTH-1] == B[WIDTH-1] && sum[WIDTH-1] != A[WIDTH-1];
      end
      4'd2: begin
        alu_res = diff;
        alu_ovf = A[WIDTH-1] != B[WIDTH-1] && diff[WIDTH-1] != A[WIDTH-1];
      end
      4'd3, 4'd4: alu_res = B;
      4'd5: alu_res = A & B;
      4'd6: alu_res = A | B;
      4'd7: alu_res = ~(A | B);
      4'd8: alu_res[0] = A < B;
      4'd9: alu_res[0] = $signed(A) < $signed(B);
      default: alu_res = '0;
    endcase
    state_n = accept && go_shift ? SHIFT : last ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      Result <= '0;
      Zero <= 1'b0;
      Overflow <= 1'b0;
      Illegal <= 1'b0;
      Done <= 1'b0;
      cnt <= '0;
      sreg <= '0;
      left <= 1'b0;
    end else begin
      state <= state_n;
      Done <= (accept && !go_shift) || last;
      if (accept && go_shift) begin
        sreg <= B;
        cnt <= Shamt;
        left <= ALU_Control == 4'd3;
      end else if (state == SHIFT) begin
        sreg <= sh_next;
        cnt <= cnt - SHAMT_W'(1);
        if (last) begin
          Result <= sh_next;
          Zero <= sh_next == '0;
          Overflow <= 1'b0;
          Illegal <= 1'b0;
        end
      end else if (accept) begin
        Result <= alu_res;
        Zero <= alu_res == '0;
        Overflow <= alu_ovf;
        Illegal <= bad;
      end
    end
  end
endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
Multi-cycle ALU datapath that executes the 4-bit ALU_Control codes produced by the ALU control decoder. It sits in the EX stage of the multi-cycle MIPS core and takes operands A (rs) and B (rt/imm) plus Shamt.
- Arithmetic and logic ops complete in one cycle.
- SLL/SRL run iteratively, one bit per cycle, with no barrel shifter.
- A Start/Busy/Done handshake lets the control FSM stall EX until the result is valid.

Parameters:
WIDTH, 32, datapath width of A, B and Result.
SHAMT_W, 5, width of Shamt and of the internal shift counter.

Ports:
clk  in  1  single system clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
Start  in  1  request to begin an operation; sampled on the rising edge.
ALU_Control  in  4  operation code: 1 ADD, 2 SUB, 3 SLL, 4 SRL, 5 AND, 6 OR, 7 NOR, 8 SLTU, 9 SLT.
A  in  WIDTH  operand 1 (rs).
B  in  WIDTH  operand 2 (rt or extended immediate); this is the value shifted for SLL/SRL.
Shamt  in  SHAMT_W  shift amount for SLL/SRL; ignored for other ops.
Result  out  WIDTH  registered result; holds until the next accepted Start.
Zero  out  1  registered; 1 when the final Result == 0.
Overflow  out  1  registered signed overflow for ADD/SUB; 0 for all other ops.
Illegal  out  1  registered; 1 when the accepted code is 0 or 10..15.
Busy  out  1  1 while an iterative shift is in progress.
Done  out  1  one-cycle pulse marking Result/flags valid.

Behaviour:
- Reset (synchronous): state=IDLE; Result=0, Zero=0, Overflow=0, Illegal=0, Busy=0, Done=0, shift counter=0.
- States: IDLE, SHIFT.
- Start is accepted only when state=IDLE (Busy=0). Start while Busy=1 is ignored and does not queue.
- All operands and the code are latched at the accepting edge. Later input changes have no effect on an operation in flight.
- Timing reference: Start is sampled high in cycle 0.
- Non-shift ops, or shift with Shamt=0:
  - Result and flags are written at the accepting edge.
  - Done=1 in cycle 1 only; state stays IDLE.
- SLL/SRL with Shamt=N>0:
  - At the accepting edge: shift register <= B, counter <= N, state <= SHIFT.
  - Busy=1 in cycles 1..N.
  - Each SHIFT edge shifts one bit (SLL: left, zero-fill; SRL: logical right, zero-fill) and decrements the counter.
  - On the edge where the counter reaches 0: Result/Zero are written, state <= IDLE, Done=1 in cycle N+1.
- Latency from Start to Done: 1 cycle for non-shift ops; N+1 cycles for shifts (maximum 32 at WIDTH=32).
- Back-to-back: Start may be high in the same cycle Done is high (state=IDLE) and is accepted.
- Arithmetic:
  - ADD/SUB are WIDTH-bit with wrap-around.
  - Overflow=1 when the operands' signs produce a result of the opposite sign: ADD with same-sign operands, SUB with different-sign operands.
  - SLT compares signed, SLTU compares unsigned. Result is 1 or 0, zero-extended to WIDTH; Overflow=0.
  - AND/OR/NOR are bitwise on A and B.
- Illegal code: Result=0, Zero=1, Overflow=0, Illegal=1, Done pulses in cycle 1. Illegal clears on the next accepted legal op.
- Flags are updated together with Result, never mid-shift. During SHIFT, Result/Zero keep their previous values.
- Reset mid-shift: operation aborted, no Done pulse, all outputs return to reset values on that edge.
- Reset and Start in the same cycle: reset wins; Start is not accepted.

Test Plan:
- ADD, A=7, B=0xFFFFFFF9, Start cycle 0 -> cycle 1: Done=1, Result=0, Zero=1, Overflow=0, Busy never 1.
- SUB, A=0x80000000, B=1 -> Result=0x7FFFFFFF, Overflow=1, Zero=0, Done in cycle 1. Then ADD 0x7FFFFFFF+1 -> Result=0x80000000, Overflow=1.
- SLL, B=1, Shamt=31 -> Busy=1 in cycles 1..31, Done only in cycle 32, Result=0x80000000. A second Start in cycle 5 (code 1) is ignored: no extra Done, Result unchanged.
- SLT then SLTU, A=0xFFFFFFFF, B=1 -> SLT Result=1; SLTU Result=0 with Zero=1. Second Start issued in the Done cycle of the first is accepted, Done in the next cycle.
- SRL, B=0xF0000000, Shamt=4, reset asserted in cycle 2 -> cycle 3: Busy=0, Done=0, Result=0. A new SRL run afterwards gives 0x0F000000 with Done in cycle 5 relative to its Start.
- ALU_Control=0 and then 4'hF -> Done in cycle 1, Illegal=1, Result=0, Zero=1. A following AND 0xFF00FF00 & 0x0FF00FF0 -> Result=0x0F000F00, Illegal=0.
